// File: rtl/pea_pkg.sv
// Shared definitions for the PEA actor datapath and its firing scheduler:
// CFDF mode codes, scheduler state encoding and FIFO geometry.
package pea_pkg;

    localparam logic [1:0] SETUP_INSTR  = 2'b00;
    localparam logic [1:0] INSTR        = 2'b01;
    localparam logic [1:0] OUTPUT       = 2'b10;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    // FIFO geometry shared with the PEA token buffers.
    localparam int BUFFER_SIZE = 16;
    localparam int WIDTH       = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_INVOKE,
        S_WAIT_FC,
        S_UPDATE,
        S_DONE,
        S_ERR
    } sched_state_t;

    function automatic logic is_legal_mode(input logic [1:0] mode);
        return mode != MODE_INVALID;
    endfunction

endpackage

// File: rtl/pea_watchdog_counter.sv
// Clearable up-counter with an equality compare against a selectable limit;
// shared by the enable-stall check and the firing-complete timeout.
module pea_watchdog_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/pea_firing_scheduler.sv
// Sequences CFDF firings of the PEA actor: checks enable, pulses invoke,
// waits for fc, latches the next mode and counts firings up to a target.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_CHECK   | sampling enable for next_instr; stall watchdog running
// S_INVOKE  | one-cycle invoke pulse
// S_WAIT_FC | waiting for fc; timeout watchdog running
// S_UPDATE  | latch next_mode_in, count the firing, decide continue/done
// S_DONE    | one-cycle done pulse
// S_ERR     | timeout or invalid mode; held until abort or rst
module pea_firing_scheduler
    import pea_pkg::*;
#(
    parameter int FIRE_W      = 8,
    parameter int TIMEOUT     = 256,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FIRE_W-1:0] num_firings,
    input  logic              enable,
    input  logic              fc,
    input  logic [1:0]        next_mode_in,
    output logic              invoke,
    output logic [1:0]        next_instr,
    output logic              busy,
    output logic              done,
    output logic              stalled,
    output logic              err,
    output logic [FIRE_W-1:0] fire_count
);

    localparam logic [CNT_W-1:0] STALL_LIM   = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT - 1);

    sched_state_t      state, state_nxt;
    logic [FIRE_W-1:0] target, target_nxt;
    logic [FIRE_W-1:0] count_nxt;
    logic [FIRE_W-1:0] count_inc;
    logic [1:0]        instr_nxt;
    logic              stalled_nxt, err_nxt;
    logic              wd_clr, wd_inc, wd_at_limit;
    logic [CNT_W-1:0]  wd_limit;

    assign count_inc = fire_count + FIRE_W'(1);
    assign wd_limit  = (state == S_CHECK) ? STALL_LIM : TIMEOUT_LIM;

    pea_watchdog_counter #(.CNT_W(CNT_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .inc      (wd_inc),
        .limit    (wd_limit),
        .at_limit (wd_at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            target     <= '0;
            fire_count <= '0;
            next_instr <= SETUP_INSTR;
            invoke     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stalled    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            fire_count <= count_nxt;
            next_instr <= instr_nxt;
            invoke     <= (state_nxt == S_INVOKE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            stalled    <= stalled_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        count_nxt   = fire_count;
        instr_nxt   = next_instr;
        stalled_nxt = stalled;
        err_nxt     = err;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;

        case (state)
            S_IDLE: begin
                wd_clr = 1'b1;
                if (start) begin
                    target_nxt  = num_firings;
                    count_nxt   = '0;
                    stalled_nxt = 1'b0;
                    err_nxt     = 1'b0;
                    instr_nxt   = SETUP_INSTR;
                    state_nxt   = (num_firings == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (enable) begin
                    wd_clr    = 1'b1;
                    state_nxt = S_INVOKE;
                end else if (wd_at_limit) begin
                    wd_clr      = 1'b1;
                    stalled_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_INVOKE: begin
                wd_clr    = 1'b1;
                state_nxt = S_WAIT_FC;
            end
            S_WAIT_FC: begin
                // fc beats a coincident watchdog expiry
                if (fc) begin
                    wd_clr    = 1'b1;
                    state_nxt = S_UPDATE;
                end else if (wd_at_limit) begin
                    wd_clr    = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_UPDATE: begin
                wd_clr = 1'b1;
                if (is_legal_mode(next_mode_in)) begin
                    instr_nxt = next_mode_in;
                    count_nxt = count_inc;
                    state_nxt = (count_inc == target) ? S_DONE : S_CHECK;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                wd_clr    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                wd_clr = 1'b1;
            end
            default: begin
                wd_clr    = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase

        // Abort discards whatever the current state was about to commit.
        if (abort && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            target_nxt  = target;
            count_nxt   = fire_count;
            instr_nxt   = next_instr;
            stalled_nxt = stalled;
            err_nxt     = err;
            wd_clr      = 1'b1;
            wd_inc      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Bench for pea_firing_scheduler: phase-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized runs.
module tb_pea_firing_scheduler;

    localparam int FIRE_W      = 8;
    localparam int TIMEOUT     = 256;
    localparam int STALL_LIMIT = 64;
    localparam int CNT_W       = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [FIRE_W-1:0] num_firings = '0;
    logic              enable;
    logic              fc;
    logic [1:0]        next_mode_in;
    logic              invoke;
    logic [1:0]        next_instr;
    logic              busy, done, stalled, err;
    logic [FIRE_W-1:0] fire_count;

    pea_firing_scheduler #(
        .FIRE_W(FIRE_W), .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_firings(num_firings),
        .enable(enable), .fc(fc), .next_mode_in(next_mode_in), .invoke(invoke),
        .next_instr(next_instr), .busy(busy), .done(done), .stalled(stalled),
        .err(err), .fire_count(fire_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int n_inv  = 0;
    int n_done = 0;
    int t0     = 0;

    // stimulus knobs
    int en_force = -1;
    int en_pct   = 100;
    int fc_fixed = 0;
    int fc_pct   = 50;
    int m11_pct  = 0;
    bit fc_force = 1'b0;
    logic [1:0] mode_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (invoke) n_inv++;
        if (done) n_done++;
    end

    // Stimulus responder: enable, fc and next_mode_in
    initial begin
        int  inv_age = 1000;
        bit  prev_fc = 1'b0;
        enable = 1'b0;
        fc = 1'b0;
        next_mode_in = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (invoke) inv_age = 0;
            else if (inv_age < 1000) inv_age++;
            enable = (en_force >= 0) ? (en_force != 0) : ($urandom_range(0, 99) < en_pct);
            if (fc_force) fc = 1'b1;
            else if (fc_fixed > 0) fc = (inv_age == fc_fixed);
            else if (fc_fixed == 0) fc = ($urandom_range(0, 99) < fc_pct);
            else fc = 1'b0;
            if (prev_fc && mode_q.size() > 0) next_mode_in = mode_q.pop_front();
            else if ($urandom_range(0, 99) < m11_pct) next_mode_in = 2'b11;
            else next_mode_in = 2'($urandom_range(0, 2));
            prev_fc = fc;
        end
    end

    // Reference model: one phase per scheduler step, dwell = cycles already spent in it
    typedef enum {P_IDLE, P_CHECK, P_INVOKE, P_WAIT, P_UPDATE, P_DONE, P_ERR} phase_t;
    phase_t ph = P_IDLE;
    int     dwell = 0;
    int     m_target = 0;
    int     m_count = 0;
    int     m_instr = 0;
    bit     m_stalled = 1'b0;
    bit     m_err = 1'b0;

    initial forever begin
        phase_t nph;
        @(posedge clk or posedge rst);
        if (rst) begin
            ph = P_IDLE; dwell = 0; m_target = 0; m_count = 0; m_instr = 0;
            m_stalled = 1'b0; m_err = 1'b0;
        end else begin
            nph = ph;
            if (abort && ph != P_IDLE) begin
                nph = P_IDLE;
            end else begin
                case (ph)
                    P_IDLE: if (start) begin
                        m_target = int'(num_firings); m_count = 0; m_instr = 0;
                        m_stalled = 1'b0; m_err = 1'b0;
                        nph = (m_target == 0) ? P_DONE : P_CHECK;
                    end
                    P_CHECK: begin
                        if (enable) nph = P_INVOKE;
                        else if (dwell + 1 == STALL_LIMIT) begin m_stalled = 1'b1; nph = P_DONE; end
                    end
                    P_INVOKE: nph = P_WAIT;
                    P_WAIT: begin
                        if (fc) nph = P_UPDATE;
                        else if (dwell + 1 == TIMEOUT) begin m_err = 1'b1; nph = P_ERR; end
                    end
                    P_UPDATE: begin
                        if (next_mode_in == 2'b11) begin m_err = 1'b1; nph = P_ERR; end
                        else begin
                            m_instr = int'(next_mode_in);
                            m_count++;
                            nph = (m_count == m_target) ? P_DONE : P_CHECK;
                        end
                    end
                    P_DONE: nph = P_IDLE;
                    default: nph = ph;
                endcase
            end
            dwell = (nph == ph) ? dwell + 1 : 0;
            ph = nph;
        end
    end

    initial forever begin
        logic [31:0] act, exp;
        @(negedge clk);
        act = {17'd0, invoke, busy, done, stalled, err, next_instr, fire_count};
        exp = {17'd0, ph == P_INVOKE, ph != P_IDLE, ph == P_DONE, m_stalled, m_err,
               2'(m_instr), 8'(m_count)};
        check("cycle{invoke,busy,done,stalled,err,instr,count}", act, exp);
    end

    task automatic start_run(input int n);
        @(posedge clk); #1;
        n_inv = 0; n_done = 0;
        start = 1'b1; num_firings = 8'(n); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // which: 0 = done, 1 = err
    task automatic wait_sig(input string name, input int which, input int budget, output int lat);
        bit found = 1'b0;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && done) || (which == 1 && err)) begin
                found = 1'b1;
                lat = cyc - t0;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {invoke, busy, done, stalled, err, next_instr, fire_count}, 32'd0);

        // three firings, fc two cycles after each invoke
        en_force = 1; fc_fixed = 2; mode_q = '{2'b01, 2'b01, 2'b10};
        start_run(3);
        wait_sig("t1_done_seen", 0, 100, lat);
        @(posedge clk); #1;
        check("t1_latency", 32'(lat), 32'd16);
        check("t1_invokes", 32'(n_inv), 32'd3);
        check("t1_dones", 32'(n_done), 32'd1);
        check("t1_fire_count", 32'(fire_count), 32'd3);
        check("t1_next_instr", 32'(next_instr), 32'd2);
        check("t1_err", 32'(err), 32'd0);

        // zero firings
        start_run(0);
        wait_sig("t2_done_seen", 0, 10, lat);
        @(posedge clk); #1;
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_invokes", 32'(n_inv), 32'd0);
        check("t2_fire_count", 32'(fire_count), 32'd0);

        // enable never rises: stall
        en_force = 0;
        start_run(5);
        wait_sig("t3_done_seen", 0, 200, lat);
        check("t3_stalled", 32'(stalled), 32'd1);
        @(posedge clk); #1;
        check("t3_latency", 32'(lat), 32'd65);
        check("t3_invokes", 32'(n_inv), 32'd0);
        check("t3_fire_count", 32'(fire_count), 32'd0);

        // fc never arrives: timeout into ERR, released by abort
        en_force = 1; fc_fixed = -1;
        start_run(2);
        wait_sig("t4_err_seen", 1, 400, lat);
        check("t4_latency", 32'(lat), 32'd259);
        repeat (5) @(posedge clk);
        #1 check("t4_busy_in_err", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_idle_after_abort", 32'(busy), 32'd0);
        check("t4_err_sticky", 32'(err), 32'd1);
        check("t4_no_done", 32'(n_done), 32'd0);

        // invalid mode on the first completion
        fc_fixed = 2; mode_q = '{2'b11};
        start_run(3);
        wait_sig("t5_err_seen", 1, 50, lat);
        check("t5_fire_count", 32'(fire_count), 32'd0);
        check("t5_next_instr", 32'(next_instr), 32'd0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;

        // asynchronous reset in the second WAIT_FC
        mode_q = '{2'b01, 2'b01, 2'b01};
        start_run(3);
        repeat (7) @(posedge clk);
        #3 check("t6_count_before_rst", 32'(fire_count), 32'd1);
        rst = 1'b1;
        #1 check("t6_reset_outputs", {invoke, busy, done, stalled, err, next_instr, fire_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mode_q.delete();

        // abort coincident with fc in WAIT_FC
        fc_fixed = -1;
        start_run(2);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1; fc_force = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; fc_force = 1'b0;
        check("t6_abort_idle", 32'(busy), 32'd0);
        check("t6_abort_count", 32'(fire_count), 32'd0);
        check("t6_abort_no_done", 32'(n_done), 32'd0);

        // randomized runs against the model
        en_force = -1; fc_fixed = 0;
        for (int r = 0; r < 40; r++) begin
            en_pct  = (r % 10 == 9) ? 0 : int'($urandom_range(40, 100));
            fc_pct  = $urandom_range(20, 100);
            m11_pct = $urandom_range(0, 4);
            @(posedge clk); #1;
            start = 1'b1;
            num_firings = 8'($urandom_range(0, 6));
            abort = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if (!busy) break;
                start = ($urandom_range(0, 15) == 0);
                num_firings = 8'($urandom_range(0, 6));
                abort = (err && busy) || ($urandom_range(0, 99) == 0);
                @(posedge clk); #1;
                start = 1'b0; abort = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
